// File: rtl/mac_pipe.sv
// rtl/mac_pipe.sv - pipelined multiply-accumulate with grouped results and valid/ready flow control
// Sample register, NUM_STAGES product registers, then the accumulator/result register.
module mac_pipe #(
  parameter int A_WIDTH    = 8,
  parameter int B_WIDTH    = 8,
  parameter int NUM_STAGES = 2,
  parameter int ACC_WIDTH  = 24,
  parameter int SATURATE   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 tc,
  input  logic [A_WIDTH-1:0]   a,
  input  logic [B_WIDTH-1:0]   b,
  input  logic                 first,
  input  logic                 last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 ovf
);

  localparam int PW   = A_WIDTH + B_WIDTH;
  localparam int LAST = NUM_STAGES - 1;
  localparam int MSB  = ACC_WIDTH - 1;

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic               s_v, s_tc, s_first, s_last;
  logic [A_WIDTH-1:0] a_q;
  logic [B_WIDTH-1:0] b_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_v     <= 1'b0;
      s_tc    <= 1'b0;
      s_first <= 1'b0;
      s_last  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else if (adv) begin
      s_v     <= in_valid;
      s_tc    <= tc;
      s_first <= first;
      s_last  <= last;
      a_q     <= a;
      b_q     <= b;
    end
  end

  // Extending both operands to the full product width makes one multiplier exact for either signedness.
  logic signed [PW-1:0] a_ext, b_ext;
  logic        [PW-1:0] prod;

  always_comb begin
    if (s_tc) begin
      a_ext = PW'($signed(a_q));
      b_ext = PW'($signed(b_q));
    end else begin
      a_ext = PW'(a_q);
      b_ext = PW'(b_q);
    end
    prod = a_ext * b_ext;
  end

  logic [PW-1:0]         p_prod [NUM_STAGES];
  logic [NUM_STAGES-1:0] p_v, p_tc, p_first, p_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_v     <= '0;
      p_tc    <= '0;
      p_first <= '0;
      p_last  <= '0;
      for (int i = 0; i < NUM_STAGES; i++) p_prod[i] <= '0;
    end else if (adv) begin
      p_v[0]     <= s_v;
      p_tc[0]    <= s_tc;
      p_first[0] <= s_first;
      p_last[0]  <= s_last;
      p_prod[0]  <= prod;
      for (int i = 1; i < NUM_STAGES; i++) begin
        p_v[i]     <= p_v[i-1];
        p_tc[i]    <= p_tc[i-1];
        p_first[i] <= p_first[i-1];
        p_last[i]  <= p_last[i-1];
        p_prod[i]  <= p_prod[i-1];
      end
    end
  end

  logic [ACC_WIDTH-1:0] acc, base, ext, sum, acc_next;
  logic                 flag, carry, ovf_now, flag_next;

  always_comb begin
    base = p_first[LAST] ? '0 : acc;
    if (p_tc[LAST]) ext = ACC_WIDTH'($signed(p_prod[LAST]));
    else            ext = ACC_WIDTH'(p_prod[LAST]);
    {carry, sum} = {1'b0, base} + {1'b0, ext};
    // Signed overflow: like-signed operands producing a result of the other sign.
    if (p_tc[LAST]) ovf_now = (base[MSB] == ext[MSB]) && (sum[MSB] != base[MSB]);
    else            ovf_now = carry;
    acc_next = sum;
    if ((SATURATE != 0) && ovf_now) begin
      if (p_tc[LAST]) acc_next = ext[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
      else            acc_next = '1;
    end
    flag_next = (p_first[LAST] ? 1'b0 : flag) | ovf_now;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      flag      <= 1'b0;
      acc_out   <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else if (adv) begin
      if (p_v[LAST]) begin
        acc  <= acc_next;
        flag <= flag_next;
      end
      out_valid <= p_v[LAST] && p_last[LAST];
      if (p_v[LAST] && p_last[LAST]) begin
        acc_out <= acc_next;
        ovf     <= flag_next;
      end
    end
  end

endmodule

// File: tb/tb_mac_pipe.sv
// tb/tb_mac_pipe.sv - directed and model-checked bench for mac_pipe
// Three instances share stimulus: default 24-bit wrap, 16-bit wrap and 16-bit saturating.
module tb_mac_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, tc, first, last, out_ready;
  logic [7:0]  a, b;
  logic        in_ready, out_valid, ovf;
  logic [23:0] acc_out;
  logic        in_ready_w, out_valid_w, ovf_w;
  logic [15:0] acc_w;
  logic        in_ready_s, out_valid_s, ovf_s;
  logic [15:0] acc_s;

  always #5 clk = ~clk;

  mac_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .tc(tc),
    .a(a), .b(b), .first(first), .last(last), .out_valid(out_valid),
    .out_ready(out_ready), .acc_out(acc_out), .ovf(ovf)
  );

  mac_pipe #(.ACC_WIDTH(16), .SATURATE(0)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w), .tc(tc),
    .a(a), .b(b), .first(first), .last(last), .out_valid(out_valid_w),
    .out_ready(out_ready), .acc_out(acc_w), .ovf(ovf_w)
  );

  mac_pipe #(.ACC_WIDTH(16), .SATURATE(1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .tc(tc),
    .a(a), .b(b), .first(first), .last(last), .out_valid(out_valid_s),
    .out_ready(out_ready), .acc_out(acc_s), .ovf(ovf_s)
  );

  typedef struct {
    logic [23:0] acc;
    logic        ovf;
    logic [15:0] accw;
    logic        ovfw;
    logic [15:0] accs;
    logic        ovfs;
  } res_t;

  int   vectors = 0;
  int   errors  = 0;
  bit   rnd_ready = 1'b0;
  res_t rq[$];
  res_t mon_r;

  // Results are captured on the cycle they are handed over.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      mon_r.acc  = acc_out;
      mon_r.ovf  = ovf;
      mon_r.accw = acc_w;
      mon_r.ovfw = ovf_w;
      mon_r.accs = acc_s;
      mon_r.ovfs = ovf_s;
      rq.push_back(mon_r);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic t, input logic f, input logic l);
    bit ok = 1'b0;
    int n  = 0;
    a = av; b = bv; tc = t; first = f; last = l; in_valid = 1'b1;
    while (!ok && n < 200) begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!ok) begin
      vectors++; errors++;
      $display("FAIL send_timeout: sample a=%0d b=%0d not accepted, got in_ready=0 want 1", av, bv);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic get(output res_t r);
    int n = 0;
    while (rq.size() == 0 && n < 500) begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      n++;
    end
    if (rq.size() == 0) begin
      vectors++; errors++;
      $display("FAIL result_timeout: got no result, want one");
      r = '{default: '0};
    end else begin
      r = rq.pop_front();
    end
  endtask

  longint m_acc [3];
  bit     m_flag[3];
  int     m_w   [3] = '{24, 16, 16};
  bit     m_sat [3] = '{1'b0, 1'b0, 1'b1};

  function automatic bit model_step(input int k, input bit t, input logic [7:0] av, input logic [7:0] bv, input bit f);
    longint m, base, prod, tru, lo, hi;
    bit o;
    m    = longint'(1) << m_w[k];
    base = f ? 0 : m_acc[k];
    if (t && base >= m / 2) base = base - m;
    prod = t ? longint'($signed(av)) * longint'($signed(bv)) : longint'(av) * longint'(bv);
    tru  = base + prod;
    lo   = t ? -(m / 2) : 0;
    hi   = t ? m / 2 - 1 : m - 1;
    o    = (tru < lo) || (tru > hi);
    m_flag[k] = (f ? 1'b0 : m_flag[k]) | o;
    if (m_sat[k] && o) tru = (tru > hi) ? hi : lo;
    m_acc[k] = ((tru % m) + m) % m;
    return m_flag[k];
  endfunction

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b1; a = 8'd9; b = 8'd9; tc = 1'b0; first = 1'b1; last = 1'b1; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++; if (acc_out !== 24'd0) begin errors++; $display("FAIL reset_acc_out: got %h want 000000", acc_out); end
    vectors++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    in_valid = 1'b0;
    rst = 1'b0;
    idle(6);
    vectors++; if (out_valid !== 1'b0 || rq.size() != 0) begin
      errors++; $display("FAIL reset_discard: got out_valid=%b results=%0d want 0/0", out_valid, rq.size());
    end
  endtask

  task automatic test_latency;
    res_t r;
    out_ready = 1'b1;
    send(8'd3, 8'd4, 1'b0, 1'b1, 1'b0);
    send(8'd5, 8'd6, 1'b0, 1'b0, 1'b0);
    send(8'd7, 8'd8, 1'b0, 1'b0, 1'b1);
    for (int e = 0; e < 3; e++) begin
      vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_early_%0d: got out_valid=%b want 0", e, out_valid); end
      idle(1);
    end
    vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL latency_edge3: got out_valid=%b want 1", out_valid); end
    vectors++; if (acc_out !== 24'd98 || ovf !== 1'b0) begin errors++; $display("FAIL latency_value: got %0d/%b want 98/0", acc_out, ovf); end
    get(r);
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_clear: got out_valid=%b want 0", out_valid); end
    vectors++; if (r.acc !== 24'd98) begin errors++; $display("FAIL latency_captured: got %0d want 98", r.acc); end
  endtask

  task automatic test_signed;
    res_t r;
    send(8'h80, 8'h80, 1'b1, 1'b1, 1'b1);
    get(r);
    vectors++; if (r.acc !== 24'd16384 || r.ovf !== 1'b0) begin errors++; $display("FAIL signed_min_sq: got %h/%b want 004000/0", r.acc, r.ovf); end
    send(8'hFD, 8'h05, 1'b1, 1'b1, 1'b1);
    get(r);
    vectors++; if (r.acc !== 24'hFFFFF1 || r.ovf !== 1'b0) begin errors++; $display("FAIL signed_neg: got %h/%b want fffff1/0", r.acc, r.ovf); end
    vectors++; if (r.accw !== 16'hFFF1) begin errors++; $display("FAIL signed_neg16: got %h want fff1", r.accw); end
  endtask

  task automatic test_overflow;
    res_t r;
    send(8'd255, 8'd255, 1'b0, 1'b1, 1'b0);
    send(8'd255, 8'd255, 1'b0, 1'b0, 1'b1);
    get(r);
    vectors++; if (r.acc !== 24'h01FC02 || r.ovf !== 1'b0) begin errors++; $display("FAIL uovf_24: got %h/%b want 01fc02/0", r.acc, r.ovf); end
    vectors++; if (r.accw !== 16'hFC02 || r.ovfw !== 1'b1) begin errors++; $display("FAIL uovf_wrap: got %h/%b want fc02/1", r.accw, r.ovfw); end
    vectors++; if (r.accs !== 16'hFFFF || r.ovfs !== 1'b1) begin errors++; $display("FAIL uovf_sat: got %h/%b want ffff/1", r.accs, r.ovfs); end
    for (int i = 0; i < 3; i++) send(8'd127, 8'd127, 1'b1, 1'(i == 0), 1'(i == 2));
    get(r);
    vectors++; if (r.acc !== 24'h00BD03 || r.ovf !== 1'b0) begin errors++; $display("FAIL sovf_pos_24: got %h/%b want 00bd03/0", r.acc, r.ovf); end
    vectors++; if (r.accw !== 16'hBD03 || r.ovfw !== 1'b1) begin errors++; $display("FAIL sovf_pos_wrap: got %h/%b want bd03/1", r.accw, r.ovfw); end
    vectors++; if (r.accs !== 16'h7FFF || r.ovfs !== 1'b1) begin errors++; $display("FAIL sovf_pos_sat: got %h/%b want 7fff/1", r.accs, r.ovfs); end
    for (int i = 0; i < 3; i++) send(8'h80, 8'd127, 1'b1, 1'(i == 0), 1'(i == 2));
    get(r);
    vectors++; if (r.acc !== 24'hFF4180 || r.ovf !== 1'b0) begin errors++; $display("FAIL sovf_neg_24: got %h/%b want ff4180/0", r.acc, r.ovf); end
    vectors++; if (r.accw !== 16'h4180 || r.ovfw !== 1'b1) begin errors++; $display("FAIL sovf_neg_wrap: got %h/%b want 4180/1", r.accw, r.ovfw); end
    vectors++; if (r.accs !== 16'h8000 || r.ovfs !== 1'b1) begin errors++; $display("FAIL sovf_neg_sat: got %h/%b want 8000/1", r.accs, r.ovfs); end
    send(8'd1, 8'd1, 1'b0, 1'b1, 1'b1);
    get(r);
    vectors++; if (r.accw !== 16'd1 || r.ovfw !== 1'b0 || r.ovfs !== 1'b0) begin
      errors++; $display("FAIL flag_cleared: got %h/%b/%b want 0001/0/0", r.accw, r.ovfw, r.ovfs);
    end
  endtask

  task automatic test_stall;
    res_t r;
    int n = 0;
    out_ready = 1'b0;
    send(8'd2, 8'd3, 1'b0, 1'b1, 1'b1);
    while (!out_valid && n < 20) begin idle(1); n++; end
    vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_pending: got out_valid=%b want 1", out_valid); end
    a = 8'd4; b = 8'd5; tc = 1'b0; first = 1'b1; last = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready_%0d: got %b want 0", c, in_ready); end
      vectors++; if (acc_out !== 24'd6 || out_valid !== 1'b1) begin
        errors++; $display("FAIL stall_hold_%0d: got %0d/%b want 6/1", c, acc_out, out_valid);
      end
    end
    vectors++; if (rq.size() != 0) begin errors++; $display("FAIL stall_no_handover: got %0d results want 0", rq.size()); end
    out_ready = 1'b1;
    send(8'd4, 8'd5, 1'b0, 1'b1, 1'b0);
    send(8'd6, 8'd7, 1'b0, 1'b0, 1'b1);
    get(r);
    vectors++; if (r.acc !== 24'd6) begin errors++; $display("FAIL stall_first_result: got %0d want 6", r.acc); end
    get(r);
    vectors++; if (r.acc !== 24'd62) begin errors++; $display("FAIL stall_next_group: got %0d want 62", r.acc); end
  endtask

  task automatic test_back_to_back;
    res_t  r;
    time   t0;
    logic [23:0] exp_v [5] = '{24'd1, 24'd4, 24'd9, 24'd16, 24'd17};
    out_ready = 1'b1;
    t0 = $time;
    for (int i = 1; i <= 4; i++) send(8'(i), 8'(i), 1'b0, 1'b1, 1'b1);
    send(8'd1, 8'd1, 1'b0, 1'b0, 1'b1);
    vectors++; if ($time - t0 != 50) begin errors++; $display("FAIL b2b_throughput: got %0t want 50", $time - t0); end
    for (int i = 0; i < 5; i++) begin
      get(r);
      vectors++; if (r.acc !== exp_v[i]) begin errors++; $display("FAIL b2b_result_%0d: got %0d want %0d", i, r.acc, exp_v[i]); end
    end
  endtask

  task automatic test_reset_mid;
    res_t r;
    out_ready = 1'b1;
    send(8'd10, 8'd10, 1'b0, 1'b1, 1'b0);
    send(8'd10, 8'd10, 1'b0, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_async: got out_valid=%b want 0", out_valid); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(6);
    vectors++; if (out_valid !== 1'b0 || rq.size() != 0) begin
      errors++; $display("FAIL midrst_flush: got out_valid=%b results=%0d want 0/0", out_valid, rq.size());
    end
    send(8'd2, 8'd2, 1'b0, 1'b0, 1'b1);
    get(r);
    vectors++; if (r.acc !== 24'd4 || r.ovf !== 1'b0) begin errors++; $display("FAIL midrst_restart: got %0d/%b want 4/0", r.acc, r.ovf); end
  endtask

  task automatic test_random;
    res_t r, e;
    res_t eq[$];
    bit   gf [3];
    int   len;
    logic [7:0] av, bv;
    bit   t;
    rnd_ready = 1'b1;
    for (int g = 0; g < 200; g++) begin
      len = $urandom_range(1, 16);
      for (int i = 0; i < len; i++) begin
        av = 8'($urandom);
        bv = 8'($urandom);
        t  = 1'($urandom_range(0, 1));
        for (int k = 0; k < 3; k++) gf[k] = model_step(k, t, av, bv, i == 0);
        idle($urandom_range(0, 2));
        send(av, bv, t, 1'(i == 0), 1'(i == len - 1));
      end
      e.acc  = m_acc[0][23:0]; e.ovf  = gf[0];
      e.accw = m_acc[1][15:0]; e.ovfw = gf[1];
      e.accs = m_acc[2][15:0]; e.ovfs = gf[2];
      eq.push_back(e);
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    for (int g = 0; g < 200; g++) begin
      get(r);
      e = eq[g];
      vectors++; if (r.acc !== e.acc || r.ovf !== e.ovf) begin
        errors++; $display("FAIL rand_24_g%0d: got %h/%b want %h/%b", g, r.acc, r.ovf, e.acc, e.ovf);
      end
      vectors++; if (r.accw !== e.accw || r.ovfw !== e.ovfw) begin
        errors++; $display("FAIL rand_wrap_g%0d: got %h/%b want %h/%b", g, r.accw, r.ovfw, e.accw, e.ovfw);
      end
      vectors++; if (r.accs !== e.accs || r.ovfs !== e.ovfs) begin
        errors++; $display("FAIL rand_sat_g%0d: got %h/%b want %h/%b", g, r.accs, r.ovfs, e.accs, e.ovfs);
      end
    end
    idle(5);
    vectors++; if (rq.size() != 0) begin errors++; $display("FAIL rand_extra: got %0d extra results want 0", rq.size()); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_signed();
    test_overflow();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
